// File: rtl/mem_copy_master.sv
// mem_copy_master: copies cmd_len 32-bit words from cmd_src to cmd_dst, one memory operation at a time
module mem_copy_master #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_start,
    input  logic [ADDRESS_WIDTH-1:0] cmd_src,
    input  logic [ADDRESS_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_WIDTH-1:0]     words_copied,
    output logic                     mem_start,
    output logic                     mem_rwn,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [31:0]              mem_data_in,
    input  logic [31:0]              mem_data_out,
    input  logic                     mem_ready
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
    state_t state;
    logic [ADDRESS_WIDTH-1:0] src_ptr, dst_ptr, src_next;
    logic [LEN_WIDTH-1:0] remaining;
    assign src_next = src_ptr + ADDRESS_WIDTH'(4);
    // Leaving the REQ state on the accepting edge keeps each request to one cycle.
    assign mem_start = (state == RD_REQ || state == WR_REQ) && mem_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_copied <= '0;
            mem_rwn      <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_start) begin
                    src_ptr      <= cmd_src;
                    dst_ptr      <= cmd_dst;
                    remaining    <= cmd_len;
                    words_copied <= '0;
                    busy         <= 1'b1;
                    if (cmd_len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= RD_REQ;
                        mem_address <= cmd_src;
                        mem_rwn     <= 1'b1;
                    end
                end
                RD_REQ: if (mem_ready) state <= RD_WAIT;
                RD_WAIT: if (mem_ready) begin
                    mem_data_in <= mem_data_out;
                    mem_address <= dst_ptr;
                    mem_rwn     <= 1'b0;
                    state       <= WR_REQ;
                end
                WR_REQ: if (mem_ready) state <= WR_WAIT;
                WR_WAIT: if (mem_ready) begin
                    words_copied <= words_copied + LEN_WIDTH'(1);
                    src_ptr      <= src_next;
                    dst_ptr      <= dst_ptr + ADDRESS_WIDTH'(4);
                    remaining    <= remaining - LEN_WIDTH'(1);
                    if (remaining == LEN_WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= RD_REQ;
                        mem_address <= src_next;
                        mem_rwn     <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: random and directed copies against a word-level copy model with a byte-array memory responder
module tb_mem_copy_master;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_start;
    logic [7:0]  cmd_src, cmd_dst, cmd_len;
    logic        busy, done, mem_start, mem_rwn, mem_ready;
    logic [7:0]  words_copied, mem_address;
    logic [31:0] mem_data_in, mem_data_out;

    mem_copy_master dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .busy(busy), .done(done), .words_copied(words_copied),
        .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory responder: busy for 1 + address[1:0] cycles after accepting a request.
    logic [7:0]  mem [256];
    logic [7:0]  img [256];
    logic        ld, mb, op_rwn;
    logic [7:0]  op_addr;
    logic [31:0] op_data;
    logic [1:0]  op_cnt;
    assign mem_ready = !mb;
    always @(posedge clk) begin
        if (ld) for (int i = 0; i < 256; i++) mem[i] <= img[i];
        if (!reset) mb <= 1'b0;
        else if (!mb && mem_start) begin
            mb      <= 1'b1;
            op_rwn  <= mem_rwn;
            op_addr <= mem_address;
            op_data <= mem_data_in;
            op_cnt  <= mem_address[1:0];
        end else if (mb) begin
            if (op_cnt == 2'd0) begin
                mb <= 1'b0;
                if (op_rwn) mem_data_out <= {mem[op_addr + 8'd3], mem[op_addr + 8'd2], mem[op_addr + 8'd1], mem[op_addr]};
                else for (int k = 0; k < 4; k++) mem[op_addr + 8'(k)] <= op_data[8*k +: 8];
            end else op_cnt <= op_cnt - 2'd1;
        end
    end

    typedef struct packed {logic rwn; logic [7:0] addr; logic [31:0] data;} op_t;
    op_t  exp_ops[$];
    logic [7:0] sh [256];
    int   total = 0, bad = 0;
    int   cyc, exp_lat, exp_len, done_cyc, n_start;
    logic track = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    function automatic logic [31:0] rd_sh(input logic [7:0] a);
        return {sh[a + 8'd3], sh[a + 8'd2], sh[a + 8'd1], sh[a]};
    endfunction

    task automatic load();
        for (int i = 0; i < 256; i++) sh[i] = img[i];
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic monitor();
        op_t op;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (track) begin
                    cyc++;
                    chk("busy", 32'(busy), 32'(cyc <= exp_lat));
                    chk("done", 32'(done), 32'(cyc == exp_lat));
                    if (done) done_cyc = cyc;
                    if (cyc == exp_lat) chk("words_copied", 32'(words_copied), 32'(exp_len));
                    if (mem_start) begin
                        n_start++;
                        chk("start_ready", 32'(mem_ready), 32'd1);
                        chk("op_pending", 32'(exp_ops.size() > 0), 32'd1);
                        if (exp_ops.size() > 0) begin
                            op = exp_ops.pop_front();
                            chk("op_rwn", 32'(mem_rwn), 32'(op.rwn));
                            chk("op_addr", 32'(mem_address), 32'(op.addr));
                            if (!op.rwn) chk("op_data", mem_data_in, op.data);
                        end
                    end
                    if (cyc > exp_lat) track = 1'b0;
                end else begin
                    chk("idle_busy", 32'(busy), 32'd0);
                    chk("idle_done", 32'(done), 32'd0);
                    chk("idle_start", 32'(mem_start), 32'd0);
                end
            end
        end
    endtask

    // Model: a plain sequential word copy on the shadow image, plus the expected op stream and latency.
    task automatic start_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        logic [7:0] a, b;
        logic [31:0] w;
        exp_len = int'(l);
        exp_lat = 1;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 8'(4 * i);
            b = d + 8'(4 * i);
            w = rd_sh(a);
            exp_ops.push_back({1'b1, a, 32'h0});
            exp_ops.push_back({1'b0, b, w});
            for (int k = 0; k < 4; k++) sh[b + 8'(k)] = w[8*k +: 8];
            exp_lat += 6 + int'(a[1:0]) + int'(b[1:0]);
        end
        @(negedge clk);
        cmd_src = s;
        cmd_dst = d;
        cmd_len = l;
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cyc = 0;
        n_start = 0;
        done_cyc = 0;
        track = 1'b1;
    endtask

    task automatic finish_cmd(input logic [7:0] l);
        int n = 0, diff = 0;
        while (track && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("timeout", 32'(track), 32'd0);
        chk("done_cyc", 32'(done_cyc), 32'(exp_lat));
        chk("n_start", 32'(n_start), 32'(2 * int'(l)));
        chk("ops_left", 32'(exp_ops.size()), 32'd0);
        for (int i = 0; i < 256; i++) if (mem[i] !== sh[i]) diff++;
        chk("mem_image", 32'(diff), 32'd0);
    endtask

    task automatic inject(input int after);
        repeat (after) @(negedge clk);
        cmd_src = 8'($urandom);
        cmd_dst = 8'($urandom);
        cmd_len = 8'($urandom_range(1, 9));
        cmd_start = 1'b1;
        @(negedge clk) cmd_start = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] s, d, l;
        cmd_start = 1'b0;
        cmd_src = '0;
        cmd_dst = '0;
        cmd_len = '0;
        ld = 1'b0;
        fork monitor(); join_none
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        {img[3], img[2], img[1], img[0]} = 32'h11223344;
        {img[7], img[6], img[5], img[4]} = 32'h55667788;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_words", 32'(words_copied), 32'd0);
        chk("rst_start", 32'(mem_start), 32'd0);
        chk("rst_rwn", 32'(mem_rwn), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", mem_data_in, 32'd0);
        load();
        @(negedge clk) reset = 1'b1;

        start_cmd(8'h00, 8'h10, 8'd2);
        finish_cmd(8'd2);
        chk("t1_w10", rd_mem(8'h10), 32'h11223344);
        chk("t1_w14", rd_mem(8'h14), 32'h55667788);
        chk("t1_lat", 32'(done_cyc), 32'd13);
        chk("t1_words", 32'(words_copied), 32'd2);

        start_cmd(8'h30, 8'h50, 8'd0);
        finish_cmd(8'd0);
        chk("len0_lat", 32'(done_cyc), 32'd1);

        for (int i = 0; i < 256; i++) img[i] = mem[i];
        {img[6], img[5], img[4], img[3]} = 32'hDEADBEEF;
        load();
        start_cmd(8'h03, 8'h21, 8'd1);
        finish_cmd(8'd1);
        chk("unal_w21", rd_mem(8'h21), 32'hDEADBEEF);
        chk("unal_lat", 32'(done_cyc), 32'd11);
        chk("unal_starts", 32'(n_start), 32'd2);

        start_cmd(8'hFC, 8'h40, 8'd2);
        finish_cmd(8'd2);
        chk("wrap_w44", rd_mem(8'h44), 32'hEF223344);
        chk("wrap_w40", rd_mem(8'h40), rd_mem(8'hFC));

        start_cmd(8'h00, 8'h60, 8'd3);
        inject(4);
        finish_cmd(8'd3);
        chk("ignore_words", 32'(words_copied), 32'd3);

        start_cmd(8'h80, 8'hA0, 8'd3);
        n = 0;
        while (!(mem_start && !mem_rwn) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wr_seen", 32'(mem_start && !mem_rwn), 32'd1);
        @(posedge clk);
        #2;
        track = 1'b0;
        exp_ops.delete();
        reset = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_words", 32'(words_copied), 32'd0);
        chk("ar_start", 32'(mem_start), 32'd0);
        chk("ar_rwn", 32'(mem_rwn), 32'd0);
        chk("ar_addr", 32'(mem_address), 32'd0);
        chk("ar_wdata", mem_data_in, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) sh[i] = mem[i];
        start_cmd(8'h84, 8'hC2, 8'd3);
        finish_cmd(8'd3);
        chk("post_rst_words", 32'(words_copied), 32'd3);

        for (int t = 0; t < 20; t++) begin
            s = 8'($urandom);
            d = 8'($urandom);
            l = 8'($urandom_range(0, 5));
            start_cmd(s, d, l);
            if (l != 0 && $urandom_range(0, 1) == 1) inject(2);
            finish_cmd(l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
